// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - framed byte-stream loader for the instruction RAM
//
// Takes a framed, little-endian byte stream from the host link, assembles
// 32-bit words, and writes them into the instruction RAM. The processor is
// held in reset until the whole image is in RAM and its checksum matches.
//
// Frame: CNT_LO CNT_HI | N*4 payload bytes (LE words) | CSUM (sum of payload mod 256)
//
// Ports:
//   Clk         system clock, rising edge
//   Reset       asynchronous active-low reset
//   byte_valid  host presents a byte
//   byte_data   stream byte
//   byte_ready  loader can accept a byte (transfer = byte_valid && byte_ready)
//   im_we       instruction RAM write strobe, one-cycle pulse
//   im_addr     instruction RAM byte address
//   im_wd       instruction RAM write data
//   cpu_reset   active-high reset to the processor
//   boot_done   image loaded and verified (sticky)
//   boot_error  framing or checksum failure (sticky)

module imem_boot_loader #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wd,
  output logic        cpu_reset,
  output logic        boot_done,
  output logic        boot_error
);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  // One extra bit so a header count of 0xFFFF compares correctly.
  localparam logic [16:0] DEPTH_LIMIT = 17'(DEPTH_WORDS);

  state_t      state;
  logic [7:0]  cnt_lo;
  logic [15:0] n_words;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [31:0] word;
  logic [7:0]  csum;

  logic        xfer;
  logic [15:0] hdr_n;
  logic [31:0] word_next;

  // Decoded from registered state only; byte_valid never feeds back here.
  assign byte_ready = Reset && ((state == S_HDR0) || (state == S_HDR1) ||
                                (state == S_DATA) || (state == S_CSUM));
  assign xfer       = byte_valid && byte_ready;
  assign hdr_n      = {byte_data, cnt_lo};

  // Word with the incoming byte dropped into its lane; on the 4th byte this
  // is the complete word and goes straight to the write-data register.
  always_comb begin
    word_next = word;
    word_next[{byte_idx, 3'b000} +: 8] = byte_data;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= S_HDR0;
      cnt_lo     <= 8'd0;
      n_words    <= 16'd0;
      word_idx   <= 16'd0;
      byte_idx   <= 2'd0;
      word       <= 32'd0;
      csum       <= 8'd0;
      im_we      <= 1'b0;
      im_addr    <= BASE_ADDR;
      im_wd      <= 32'd0;
      cpu_reset  <= 1'b1;
      boot_done  <= 1'b0;
      boot_error <= 1'b0;
    end else begin
      case (state)
        S_HDR0: begin
          if (xfer) begin
            cnt_lo <= byte_data;
            state  <= S_HDR1;
          end
        end

        S_HDR1: begin
          if (xfer) begin
            n_words <= hdr_n;
            if ({1'b0, hdr_n} > DEPTH_LIMIT) begin
              state      <= S_ERROR;
              boot_error <= 1'b1;
            end else if (hdr_n == 16'd0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (xfer) begin
            word     <= word_next;
            csum     <= csum + byte_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              // Outputs are registered, so the strobe is high exactly while
              // the state is WRITE.
              im_we   <= 1'b1;
              im_wd   <= word_next;
              im_addr <= BASE_ADDR + {14'd0, word_idx, 2'b00};
              state   <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          im_we    <= 1'b0;
          word_idx <= word_idx + 16'd1;
          if ((word_idx + 16'd1) == n_words) begin
            state <= S_CSUM;
          end else begin
            state <= S_DATA;
          end
        end

        S_CSUM: begin
          if (xfer) begin
            if (byte_data == csum) begin
              state     <= S_DONE;
              cpu_reset <= 1'b0;
              boot_done <= 1'b1;
            end else begin
              state      <= S_ERROR;
              boot_error <= 1'b1;
            end
          end
        end

        S_DONE: begin
          state <= S_DONE;
        end

        S_ERROR: begin
          state <= S_ERROR;
        end

        default: begin
          state      <= S_ERROR;
          im_we      <= 1'b0;
          cpu_reset  <= 1'b1;
          boot_done  <= 1'b0;
          boot_error <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed scoreboard bench for imem_boot_loader

module tb_imem_boot_loader;

  logic        Clk;
  logic        Reset;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wd;
  logic        cpu_reset;
  logic        boot_done;
  logic        boot_error;

  int vectors;
  int miscompares;

  logic [63:0] exp_q[$];   // {addr, data} of required RAM writes, in order
  logic [7:0]  frame[$];
  logic        prev_we;

  imem_boot_loader #(
    .DEPTH_WORDS(64),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_wd     (im_wd),
    .cpu_reset (cpu_reset),
    .boot_done (boot_done),
    .boot_error(boot_error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write monitor: pops the scoreboard on every strobe, sampled mid-cycle.
  always @(negedge Clk) begin
    if (Reset === 1'b1 && im_we === 1'b1) begin
      chk("we_ready_low", {63'd0, byte_ready}, 64'd0);
      chk("we_one_cycle", {63'd0, prev_we}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {im_addr, im_wd}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("write_addr_data", {im_addr, im_wd}, exp_q.pop_front());
      end
    end
    prev_we <= im_we;
  end

  // Called at a negedge; returns at the negedge just after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        @(negedge Clk);
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    budget     = 0;
    while (byte_ready !== 1'b1 && budget < 50) begin
      @(negedge Clk);
      budget++;
    end
    if (budget >= 50) begin
      chk("ready_timeout", 64'(budget), 64'd0);
    end
    @(negedge Clk);
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
  endtask

  task automatic send_frame(input bit gaps);
    for (int i = 0; i < frame.size(); i++) begin
      send_byte(frame[i], gaps);
    end
  endtask

  task automatic nominal_frame(input logic [7:0] last);
    frame = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
              8'hEF, 8'hBE, 8'hAD, 8'hDE, last};
  endtask

  task automatic push_nominal_writes();
    exp_q.push_back({32'h0000_0000, 32'h1234_5678});
    exp_q.push_back({32'h0000_0004, 32'hDEAD_BEEF});
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic check_end(input string tag, input logic done, input logic err);
    chk({tag, "_done"},     {63'd0, boot_done},  {63'd0, done});
    chk({tag, "_error"},    {63'd0, boot_error}, {63'd0, err});
    chk({tag, "_cpu_rst"},  {63'd0, cpu_reset},  {63'd0, ~done});
    chk({tag, "_ready"},    {63'd0, byte_ready}, 64'd0);
    chk({tag, "_q_empty"},  64'(exp_q.size()),   64'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    prev_we     = 1'b0;
    Reset       = 1'b0;
    byte_valid  = 1'b0;
    byte_data   = 8'h00;

    // Reset state
    repeat (2) @(negedge Clk);
    chk("rst_we",      {63'd0, im_we},      64'd0);
    chk("rst_addr",    {32'd0, im_addr},    64'd0);
    chk("rst_wd",      {32'd0, im_wd},      64'd0);
    chk("rst_cpu",     {63'd0, cpu_reset},  64'd1);
    chk("rst_done",    {63'd0, boot_done},  64'd0);
    chk("rst_err",     {63'd0, boot_error}, 64'd0);
    chk("rst_ready",   {63'd0, byte_ready}, 64'd0);
    Reset = 1'b1;
    @(negedge Clk);
    chk("idle_ready",  {63'd0, byte_ready}, 64'd1);

    // Nominal load, with write latency and done timing checked
    nominal_frame(8'h4C);
    push_nominal_writes();
    for (int i = 0; i < frame.size(); i++) begin
      send_byte(frame[i], 1'b0);
      if (i == 5 || i == 9) chk("write_latency", {63'd0, im_we}, 64'd1);
    end
    chk("nom_done_first_cycle", {63'd0, boot_done}, 64'd1);
    repeat (3) @(negedge Clk);
    check_end("nominal", 1'b1, 1'b0);
    chk("nom_addr_hold", {im_addr, im_wd}, {32'h0000_0004, 32'hDEAD_BEEF});

    // Bad checksum
    do_reset();
    nominal_frame(8'h4D);
    push_nominal_writes();
    send_frame(1'b0);
    chk("bad_csum_err_first_cycle", {63'd0, boot_error}, 64'd1);
    repeat (3) @(negedge Clk);
    check_end("bad_csum", 1'b0, 1'b1);

    // Empty image
    do_reset();
    frame = '{8'h00, 8'h00, 8'h00};
    send_frame(1'b0);
    repeat (3) @(negedge Clk);
    check_end("empty", 1'b1, 1'b0);

    // Oversize header: 65 words > 64
    do_reset();
    frame = '{8'h41, 8'h00};
    send_frame(1'b0);
    chk("oversize_err_now",   {63'd0, boot_error}, 64'd1);
    chk("oversize_ready_now", {63'd0, byte_ready}, 64'd0);
    byte_valid = 1'b1;
    byte_data  = 8'h00;
    repeat (3) @(negedge Clk);
    byte_valid = 1'b0;
    check_end("oversize", 1'b0, 1'b1);

    // Exactly DEPTH_WORDS is accepted as a count (not an error)
    do_reset();
    frame = '{8'h40, 8'h00};
    send_frame(1'b0);
    chk("depth_limit_no_err",  {63'd0, boot_error}, 64'd0);
    chk("depth_limit_ready",   {63'd0, byte_ready}, 64'd1);

    // Backpressure and gaps
    do_reset();
    nominal_frame(8'h4C);
    push_nominal_writes();
    send_frame(1'b1);
    repeat (3) @(negedge Clk);
    check_end("gaps", 1'b1, 1'b0);

    // Reset mid-load after 6 payload bytes, then a full reload
    do_reset();
    frame = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE};
    exp_q.push_back({32'h0000_0000, 32'h1234_5678});
    send_frame(1'b0);
    Reset = 1'b0;
    #1;
    chk("midrst_wd",    {32'd0, im_wd},      64'd0);
    chk("midrst_addr",  {32'd0, im_addr},    64'd0);
    chk("midrst_cpu",   {63'd0, cpu_reset},  64'd1);
    chk("midrst_ready", {63'd0, byte_ready}, 64'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    nominal_frame(8'h4C);
    push_nominal_writes();
    send_frame(1'b0);
    repeat (3) @(negedge Clk);
    check_end("reload", 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
